costas_loop_filter: RTL and testbench



---
 rtl/costas_pkg.sv | 35 +++
 rtl/costas_lock_detect.sv | 69 ++++++
 rtl/costas_loop_filter.sv | 136 +++++++++++++
 tb/tb_costas_loop_filter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/costas_pkg.sv
// Shared types, constants and helpers for the Costas loop filter.
package costas_pkg;

    // Phase detector selection.
    localparam logic ModeBpsk = 1'b0;
    localparam logic ModeQpsk = 1'b1;

    // Lock detector state encoding.
    typedef enum logic {
        LockAcquire = 1'b0,
        LockTrack   = 1'b1
    } lock_state_e;

    // The detector error needs one bit more than the samples so that
    // negating the most negative sample cannot wrap.
    function automatic int unsigned err_width(input int unsigned width);
        return width + 1;
    endfunction

    // Clamp a sign-extended value to the signed range of a width-bit word.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                        input int unsigned       width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/costas_lock_detect.sv
// Lock detector: counts consecutive in/out-of-threshold error magnitudes.
module costas_lock_detect
    import costas_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned ERR_W        = 17,
    parameter int unsigned LOCK_COUNT   = 16,
    parameter int unsigned UNLOCK_COUNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [ERR_W-1:0] err_mag,
    input  logic [WIDTH-1:0] lock_thresh,
    output logic             locked
);

    localparam int unsigned CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CntMax      = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] LockTarget  = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UnlockTarget = CNT_W'(UNLOCK_COUNT);

    lock_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             good;

    // Threshold compare and saturating counter increment.
    always_comb begin
        good    = err_mag < {{(ERR_W - WIDTH){1'b0}}, lock_thresh};
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end

    // Lock FSM with registered lock flag, advanced once per valid error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LockAcquire;
            cnt_q   <= '0;
            locked  <= 1'b0;
        end else if (valid) begin
            unique case (state_q)
                LockAcquire: begin
                    if (!good) begin
                        cnt_q <= '0;
                    end else if (cnt_inc == LockTarget) begin
                        state_q <= LockTrack;
                        cnt_q   <= '0;
                        locked  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                LockTrack: begin
                    if (good) begin
                        cnt_q <= '0;
                    end else if (cnt_inc == UnlockTarget) begin
                        state_q <= LockAcquire;
                        cnt_q   <= '0;
                        locked  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/costas_loop_filter.sv
// Costas phase detector followed by a saturating PI loop filter and lock detector.
module costas_loop_filter
    import costas_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned ACC_W        = 24,
    parameter int unsigned LOCK_COUNT   = 16,
    parameter int unsigned UNLOCK_COUNT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MODE,
    input  logic [3:0]              KP_SHIFT,
    input  logic [3:0]              KI_SHIFT,
    input  logic [WIDTH-1:0]        LOCK_THRESH,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] iq_tdata_i,
    input  logic signed [WIDTH-1:0] iq_tdata_q,
    input  logic                    iq_tvalid,
    output logic signed [WIDTH-1:0] feedback_tdata,
    output logic                    feedback_tvalid,
    output logic                    locked
);

    localparam int unsigned ERR_W  = err_width(WIDTH);
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned FRAC_W = ACC_W - WIDTH;

    logic signed [ERR_W-1:0] i_ext, q_ext, term_q, term_i, err_d;
    logic signed [ERR_W-1:0] err_q;
    logic                    valid1_q;

    logic signed [ERR_W-1:0] ki_term, p_d, p_q;
    logic [ERR_W-1:0]        err_mag_d, err_mag_q;
    logic signed [SUM_W-1:0] integ_sum;
    logic signed [63:0]      integ_sat;
    logic signed [ACC_W-1:0] integ_d, integ_q;
    logic                    valid2_q;

    logic signed [ACC_W-1:0] integ_scaled;
    logic signed [SUM_W-1:0] fb_sum;
    logic signed [63:0]      fb_sat;

    logic unused_sat_bits;
    assign unused_sat_bits = ^{integ_sat[63:ACC_W], fb_sat[63:WIDTH]};

    // Stage 1: sign-multiply detector, computed at ERR_W so negation never wraps.
    always_comb begin
        i_ext  = {iq_tdata_i[WIDTH-1], iq_tdata_i};
        q_ext  = {iq_tdata_q[WIDTH-1], iq_tdata_q};
        term_q = i_ext[ERR_W-1] ? -q_ext : q_ext;
        term_i = q_ext[ERR_W-1] ? -i_ext : i_ext;
        err_d  = (MODE == ModeQpsk) ? term_q - term_i : term_q;
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= '0;
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= iq_tvalid;
            if (iq_tvalid) begin
                err_q <= err_d;
            end
        end
    end

    // Stage 2: integrator update with saturation; clear wins over an update.
    always_comb begin
        ki_term   = err_q >>> KI_SHIFT;
        p_d       = err_q >>> KP_SHIFT;
        err_mag_d = err_q[ERR_W-1] ? -err_q : err_q;
        integ_sum = {integ_q[ACC_W-1], integ_q} + {{FRAC_W{ki_term[ERR_W-1]}}, ki_term};
        integ_sat = sat_to_width({{(64 - SUM_W){integ_sum[SUM_W-1]}}, integ_sum}, ACC_W);
        integ_d   = integ_q;
        if (clear) begin
            integ_d = '0;
        end else if (valid1_q) begin
            integ_d = integ_sat[ACC_W-1:0];
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ_q   <= '0;
            p_q       <= '0;
            err_mag_q <= '0;
            valid2_q  <= 1'b0;
        end else begin
            integ_q  <= integ_d;
            valid2_q <= valid1_q;
            if (valid1_q) begin
                p_q       <= p_d;
                err_mag_q <= err_mag_d;
            end
        end
    end

    // Stage 3: proportional plus scaled integrator, clamped to the output width.
    always_comb begin
        integ_scaled = integ_q >>> FRAC_W;
        fb_sum = {{(SUM_W - ERR_W){p_q[ERR_W-1]}}, p_q}
               + {integ_scaled[ACC_W-1], integ_scaled};
        fb_sat = sat_to_width({{(64 - SUM_W){fb_sum[SUM_W-1]}}, fb_sum}, WIDTH);
    end

    // Stage 3 register: output word holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feedback_tdata  <= '0;
            feedback_tvalid <= 1'b0;
        end else begin
            feedback_tvalid <= valid2_q;
            if (valid2_q) begin
                feedback_tdata <= fb_sat[WIDTH-1:0];
            end
        end
    end

    costas_lock_detect #(
        .WIDTH        (WIDTH),
        .ERR_W        (ERR_W),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_lock_detect (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid2_q),
        .err_mag     (err_mag_q),
        .lock_thresh (LOCK_THRESH),
        .locked      (locked)
    );

endmodule

// File: tb/tb_costas_loop_filter.sv
// Directed bench for costas_loop_filter with hand-computed expectations.
module tb_costas_loop_filter;

    localparam int WIDTH = 16;
    localparam int ACC_W = 24;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    mode = 1'b0;
    logic [3:0]              kp_shift = 4'd0;
    logic [3:0]              ki_shift = 4'd0;
    logic [WIDTH-1:0]        lock_thresh = '0;
    logic                    clear = 1'b0;
    logic signed [WIDTH-1:0] iq_i = '0;
    logic signed [WIDTH-1:0] iq_q = '0;
    logic                    iq_tvalid = 1'b0;
    logic signed [WIDTH-1:0] feedback_tdata;
    logic                    feedback_tvalid;
    logic                    locked;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    costas_loop_filter dut (
        .clk             (clk),
        .rst             (rst),
        .MODE            (mode),
        .KP_SHIFT        (kp_shift),
        .KI_SHIFT        (ki_shift),
        .LOCK_THRESH     (lock_thresh),
        .clear           (clear),
        .iq_tdata_i      (iq_i),
        .iq_tdata_q      (iq_q),
        .iq_tvalid       (iq_tvalid),
        .feedback_tdata  (feedback_tdata),
        .feedback_tvalid (feedback_tvalid),
        .locked          (locked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        iq_tvalid = 1'b0;
        clear     = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (feedback_tdata !== 16'sd0 || feedback_tvalid !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got data=%0d valid=%b locked=%b want 0 0 0",
                     feedback_tdata, feedback_tvalid, locked);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (feedback_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got valid=%b want 0", k, feedback_tvalid);
            end
        end
    endtask

    task automatic test_bpsk_single();
        do_reset();
        mode = 1'b0; kp_shift = 4'd4; ki_shift = 4'd8; lock_thresh = '0;
        iq_i = 16'sd1000; iq_q = 16'sd256; iq_tvalid = 1'b1;
        tick();
        iq_tvalid = 1'b0;
        tick();
        checks++;
        if (feedback_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bpsk_early got valid=%b want 0", feedback_tvalid);
        end
        tick();
        checks++;
        if (feedback_tvalid !== 1'b1 || feedback_tdata !== 16'sd16) begin
            errors++;
            $display("FAIL bpsk_out got valid=%b data=%0d want 1 16",
                     feedback_tvalid, feedback_tdata);
        end
        checks++;
        if (dut.integ_q !== 24'sd1) begin
            errors++;
            $display("FAIL bpsk_integ got %0d want 1", dut.integ_q);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (feedback_tvalid !== 1'b0 || feedback_tdata !== 16'sd16) begin
                errors++;
                $display("FAIL bpsk_hold cycle %0d got valid=%b data=%0d want 0 16",
                         k, feedback_tvalid, feedback_tdata);
            end
        end
    endtask

    task automatic test_qpsk();
        do_reset();
        mode = 1'b1; kp_shift = 4'd4; ki_shift = 4'd8; lock_thresh = '0;
        // err = -1*200 - (+1)*(-100) = -100; p = -7, integ = -1, out = -7 + -1.
        iq_i = -16'sd100; iq_q = 16'sd200; iq_tvalid = 1'b1;
        tick();
        iq_tvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (feedback_tvalid !== 1'b1 || feedback_tdata !== -16'sd8) begin
            errors++;
            $display("FAIL qpsk_out got valid=%b data=%0d want 1 -8",
                     feedback_tvalid, feedback_tdata);
        end
        checks++;
        if (dut.integ_q !== -24'sd1) begin
            errors++;
            $display("FAIL qpsk_integ got %0d want -1", dut.integ_q);
        end
        // Most negative on both rails: err = 32768 - 32768 = 0.
        iq_i = -16'sd32768; iq_q = -16'sd32768; iq_tvalid = 1'b1;
        tick();
        iq_tvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (feedback_tvalid !== 1'b1 || feedback_tdata !== -16'sd1) begin
            errors++;
            $display("FAIL qpsk_minneg_out got valid=%b data=%0d want 1 -1",
                     feedback_tvalid, feedback_tdata);
        end
        checks++;
        if (dut.integ_q !== -24'sd1) begin
            errors++;
            $display("FAIL qpsk_minneg_integ got %0d want -1", dut.integ_q);
        end
    endtask

    task automatic test_saturation();
        int n;
        int wrapped;
        n = 300;
        wrapped = 0;
        do_reset();
        mode = 1'b0; kp_shift = 4'd0; ki_shift = 4'd0; lock_thresh = '0;
        iq_i = 16'sd32767; iq_q = 16'sd32767;
        for (int k = 0; k < n + 2; k++) begin
            iq_tvalid = (k < n);
            tick();
            if (dut.integ_q < 0) wrapped++;
            if (k >= 2) begin
                checks++;
                if (feedback_tvalid !== 1'b1 || feedback_tdata !== 16'sd32767) begin
                    errors++;
                    $display("FAIL sat_out strobe %0d got valid=%b data=%0d want 1 32767",
                             k - 2, feedback_tvalid, feedback_tdata);
                end
            end
        end
        iq_tvalid = 1'b0;
        checks++;
        if (wrapped != 0) begin
            errors++;
            $display("FAIL sat_wrap got %0d negative integ cycles want 0", wrapped);
        end
        checks++;
        if (dut.integ_q !== 24'sd8388607) begin
            errors++;
            $display("FAIL sat_integ got %0d want 8388607", dut.integ_q);
        end
    endtask

    task automatic test_lock();
        int n;
        logic [47:0] bad_mask;
        logic exp_locked;
        n = 48;
        // Index 15 is the lone bad in acquire; 32..38 and 40..47 are bad in track.
        bad_mask = '0;
        bad_mask[15] = 1'b1;
        for (int s = 32; s < 48; s++) bad_mask[s] = (s != 39);
        do_reset();
        mode = 1'b0; kp_shift = 4'd0; ki_shift = 4'd0; lock_thresh = 16'd64;
        iq_i = 16'sd1;
        for (int k = 0; k < n + 2; k++) begin
            iq_tvalid = (k < n);
            if (k < n) iq_q = bad_mask[k] ? 16'sd100 : 16'sd10;
            tick();
            if (k >= 2) begin
                exp_locked = (k - 2 >= 31) && (k - 2 < 47);
                checks++;
                if (feedback_tvalid !== 1'b1 || locked !== exp_locked) begin
                    errors++;
                    $display("FAIL lock_seq strobe %0d got valid=%b locked=%b want 1 %b",
                             k - 2, feedback_tvalid, locked, exp_locked);
                end
            end
        end
        iq_tvalid = 1'b0;
    endtask

    task automatic test_lock_threshold_edge();
        do_reset();
        mode = 1'b0; kp_shift = 4'd0; ki_shift = 4'd0; lock_thresh = 16'd64;
        iq_i = 16'sd1;
        // |err| equal to the threshold is not good; one below it is.
        for (int k = 0; k < 34; k++) begin
            iq_tvalid = (k < 32);
            iq_q = (k < 16) ? 16'sd64 : 16'sd63;
            tick();
            if (k == 17) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_equal_thresh got locked=%b want 0", locked);
                end
            end
            if (k == 32) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_below_15 got locked=%b want 0", locked);
                end
            end
            if (k == 33) begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_below_16 got locked=%b want 1", locked);
                end
            end
        end
        iq_tvalid = 1'b0;
    endtask

    task automatic test_sparse_clear();
        int exp_fb [3] = '{65, 69, 73};
        do_reset();
        mode = 1'b0; kp_shift = 4'd4; ki_shift = 4'd0; lock_thresh = '0;
        iq_i = 16'sd5; iq_q = 16'sd1000;
        // err = 1000, p = 62, integ steps by 1000 per valid sample.
        for (int n = 1; n <= 3; n++) begin
            iq_tvalid = 1'b1;
            tick();
            iq_tvalid = 1'b0;
            checks++;
            if (dut.integ_q !== 24'((n - 1) * 1000)) begin
                errors++;
                $display("FAIL sparse_hold n=%0d got %0d want %0d", n, dut.integ_q, (n - 1) * 1000);
            end
            tick();
            checks++;
            if (dut.integ_q !== 24'(n * 1000)) begin
                errors++;
                $display("FAIL sparse_integ n=%0d got %0d want %0d", n, dut.integ_q, n * 1000);
            end
            tick();
            checks++;
            if (feedback_tvalid !== 1'b1 || feedback_tdata !== 16'(exp_fb[n - 1])) begin
                errors++;
                $display("FAIL sparse_out n=%0d got valid=%b data=%0d want 1 %0d",
                         n, feedback_tvalid, feedback_tdata, exp_fb[n - 1]);
            end
        end
        // Clear lands on the same edge as this sample's integrator update.
        iq_tvalid = 1'b1;
        tick();
        iq_tvalid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (dut.integ_q !== 24'sd0) begin
            errors++;
            $display("FAIL clear_integ got %0d want 0", dut.integ_q);
        end
        tick();
        checks++;
        if (feedback_tvalid !== 1'b1 || feedback_tdata !== 16'sd62) begin
            errors++;
            $display("FAIL clear_out got valid=%b data=%0d want 1 62",
                     feedback_tvalid, feedback_tdata);
        end
        iq_tvalid = 1'b1;
        tick();
        iq_tvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (feedback_tdata !== 16'sd65 || dut.integ_q !== 24'sd1000) begin
            errors++;
            $display("FAIL post_clear got data=%0d integ=%0d want 65 1000",
                     feedback_tdata, dut.integ_q);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b0; kp_shift = 4'd0; ki_shift = 4'd0; lock_thresh = 16'd64;
        iq_i = 16'sd1; iq_q = 16'sd10;
        for (int k = 0; k < 18; k++) begin
            iq_tvalid = (k < 16);
            tick();
        end
        checks++;
        if (locked !== 1'b1 || feedback_tdata !== 16'sd10) begin
            errors++;
            $display("FAIL async_prelock got locked=%b data=%0d want 1 10", locked, feedback_tdata);
        end
        // Two samples in flight when reset hits between edges.
        iq_tvalid = 1'b1;
        tick();
        tick();
        iq_tvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (feedback_tdata !== 16'sd0 || feedback_tvalid !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got data=%0d valid=%b locked=%b want 0 0 0",
                     feedback_tdata, feedback_tvalid, locked);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (feedback_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL async_discard cycle %0d got valid=%b want 0", k, feedback_tvalid);
            end
        end
        iq_tvalid = 1'b1;
        tick();
        iq_tvalid = 1'b0;
        tick();
        checks++;
        if (feedback_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL async_early got valid=%b want 0", feedback_tvalid);
        end
        tick();
        checks++;
        if (feedback_tvalid !== 1'b1 || feedback_tdata !== 16'sd10) begin
            errors++;
            $display("FAIL async_first got valid=%b data=%0d want 1 10",
                     feedback_tvalid, feedback_tdata);
        end
    endtask

    initial begin
        test_reset();
        test_bpsk_single();
        test_qpsk();
        test_saturation();
        test_lock();
        test_lock_threshold_edge();
        test_sparse_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
